// File: rtl/tt_um_reg_bank.sv
// tt_um_reg_bank: NREGS x WIDTH register bank with shared-bus write ops, carry and zero flags.
// One op per cycle on register wr_sel; combinational read port on rd_sel.
module tt_um_reg_bank #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int SELW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             wr_en,
  input  logic [SELW-1:0]  wr_sel,
  input  logic [2:0]       op,
  input  logic [SELW-1:0]  rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             carry,
  output logic             zero
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] cur, nxt;
  logic nc, wr_ok, rd_ok;
  // selects past NREGS only exist for non-power-of-two banks
  assign wr_ok = wr_en && (int'(wr_sel) < NREGS);
  assign rd_ok = int'(rd_sel) < NREGS;
  assign rd_data = rd_ok ? regs[rd_sel] : '0;
  assign cur = wr_ok ? regs[wr_sel] : '0;
  always_comb begin
    nxt = cur;
    nc = carry;
    case (op)
      3'd1: nxt = bus_in;
      3'd2: begin
        nxt = '0;
        nc = 1'b0;
      end
      3'd3: {nc, nxt} = {1'b0, cur} + (WIDTH+1)'(1);
      3'd4: begin
        nxt = cur - WIDTH'(1);
        nc = cur == '0;
      end
      3'd5: begin
        nxt = {cur[WIDTH-2:0], 1'b0};
        nc = cur[WIDTH-1];
      end
      3'd6: begin
        nxt = {1'b0, cur[WIDTH-1:1]};
        nc = cur[0];
      end
      3'd7: begin
        nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
        nc = cur[WIDTH-1];
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      carry <= 1'b0;
      zero <= 1'b1;
    end else if (wr_ok) begin
      regs[wr_sel] <= nxt;
      carry <= nc;
      zero <= nxt == '0;
    end
  end
endmodule
